// File: rtl/ms5611_frame_unpack.sv
// Drains the MS5611 SPI driver receive FIFO after each data-ready strobe and
// unpacks PROM coefficients C1..C6 or raw D2/D1 conversions onto registered outputs.
module ms5611_frame_unpack #(
  parameter int         FIFO_RD_LAT = 1,
  parameter logic [2:0] STA_INIT    = 3'd1,
  parameter logic [2:0] STA_SEND    = 3'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Dat_Rdy_Sig,
  input  logic [2:0]  sta_in,
  input  logic [3:0]  Rx_Dat_Cnt,
  input  logic        Rx_FIFO_Full,
  input  logic [7:0]  Rx_FIFO_dat,
  output logic        Rx_FIFO_RD_Req,
  output logic [15:0] prom_c1,
  output logic [15:0] prom_c2,
  output logic [15:0] prom_c3,
  output logic [15:0] prom_c4,
  output logic [15:0] prom_c5,
  output logic [15:0] prom_c6,
  output logic        prom_valid,
  output logic [23:0] d1_raw,
  output logic [23:0] d2_raw,
  output logic        meas_valid,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CAP, S_DONE} state_t;

  localparam logic [1:0] WAIT_LOAD = (FIFO_RD_LAT > 1) ? 2'(FIFO_RD_LAT - 2) : 2'd0;

  state_t            state_q, state_d;
  logic              is_prom_q, is_prom_d;
  logic [4:0]        k_q, k_d, k_next, frame_len;
  logic [1:0]        wait_q, wait_d;
  logic [13:0][7:0]  buf_q, buf_d;
  logic [5:0][15:0]  prom_q, prom_d, words;
  logic              prom_valid_q, prom_valid_d;
  logic              meas_valid_q, meas_valid_d;
  logic              frame_err_q, frame_err_d;
  logic [23:0]       d1_q, d1_d, d2_q, d2_d;
  logic              fifo_empty, bad_word, rd_req;

  function automatic logic is_bad(input logic [15:0] w);
    return (w == 16'h0000) || (w == 16'hFFFF);
  endfunction

  assign fifo_empty = (Rx_Dat_Cnt == 4'd0) && !Rx_FIFO_Full;
  assign frame_len  = is_prom_q ? 5'd16 : 5'd6;
  assign k_next     = k_q + 5'd1;

  // Bytes 14/15 are never used, so only the first 14 byte slots are kept.
  always_comb begin
    words[0] = {buf_q[2],  buf_q[3]};
    words[1] = {buf_q[4],  buf_q[5]};
    words[2] = {buf_q[6],  buf_q[7]};
    words[3] = {buf_q[8],  buf_q[9]};
    words[4] = {buf_q[10], buf_q[11]};
    words[5] = {buf_q[12], buf_q[13]};
    bad_word = is_bad(words[0]) | is_bad(words[1]) | is_bad(words[2]) |
               is_bad(words[3]) | is_bad(words[4]) | is_bad(words[5]);
  end

  always_comb begin
    state_d      = state_q;
    is_prom_d    = is_prom_q;
    k_d          = k_q;
    wait_d       = wait_q;
    buf_d        = buf_q;
    prom_d       = prom_q;
    prom_valid_d = prom_valid_q;
    meas_valid_d = 1'b0;
    frame_err_d  = frame_err_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    rd_req       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Dat_Rdy_Sig) begin
          if (sta_in == STA_INIT) begin
            is_prom_d = 1'b1;
            k_d       = '0;
            state_d   = S_RD;
          end else if (sta_in == STA_SEND) begin
            is_prom_d = 1'b0;
            k_d       = '0;
            state_d   = S_RD;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (fifo_empty) begin
          frame_err_d = 1'b1;
          state_d     = S_IDLE;
        end else begin
          rd_req = 1'b1;
          if (FIFO_RD_LAT > 1) begin
            wait_d  = WAIT_LOAD;
            state_d = S_WAIT;
          end else begin
            state_d = S_CAP;
          end
        end
      end
      S_WAIT: begin
        if (wait_q == 2'd0) state_d = S_CAP;
        else                wait_d  = wait_q - 2'd1;
      end
      S_CAP: begin
        if (k_q < 5'd14) buf_d[k_q[3:0]] = Rx_FIFO_dat;
        if (is_prom_q && (k_q == 5'd0)) prom_valid_d = 1'b0;
        k_d = k_next;
        // The last byte is taken straight from the FIFO so results appear in DONE.
        if (k_next == frame_len) begin
          state_d = S_DONE;
          if (is_prom_q) begin
            prom_d       = words;
            prom_valid_d = 1'b1;
            if (bad_word) frame_err_d = 1'b1;
          end else if (prom_valid_q) begin
            d2_d         = {buf_q[0], buf_q[1], buf_q[2]};
            d1_d         = {buf_q[3], buf_q[4], Rx_FIFO_dat};
            meas_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (Dat_Rdy_Sig && (state_q != S_IDLE)) frame_err_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      is_prom_q    <= 1'b0;
      k_q          <= '0;
      wait_q       <= '0;
      buf_q        <= '0;
      prom_q       <= '0;
      prom_valid_q <= 1'b0;
      meas_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      d1_q         <= '0;
      d2_q         <= '0;
    end else begin
      state_q      <= state_d;
      is_prom_q    <= is_prom_d;
      k_q          <= k_d;
      wait_q       <= wait_d;
      buf_q        <= buf_d;
      prom_q       <= prom_d;
      prom_valid_q <= prom_valid_d;
      meas_valid_q <= meas_valid_d;
      frame_err_q  <= frame_err_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
    end
  end

  assign Rx_FIFO_RD_Req = rd_req;
  assign prom_c1        = prom_q[0];
  assign prom_c2        = prom_q[1];
  assign prom_c3        = prom_q[2];
  assign prom_c4        = prom_q[3];
  assign prom_c5        = prom_q[4];
  assign prom_c6        = prom_q[5];
  assign prom_valid     = prom_valid_q;
  assign meas_valid     = meas_valid_q;
  assign frame_err      = frame_err_q;
  assign d1_raw         = d1_q;
  assign d2_raw         = d2_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ms5611_frame_unpack.sv
// Directed bench for ms5611_frame_unpack: one DUT at FIFO latency 1, one at latency 2,
// each fed by a small FIFO model.
module tb_ms5611_frame_unpack;

  localparam logic [127:0] PROM_BYTES = 128'h0000_9CBF_903C_5B15_5AF2_82B8_6E98_000B;
  localparam logic [95:0]  EXP_COEFS  = 96'h9CBF_903C_5B15_5AF2_82B8_6E98;

  logic CLK = 1'b0, RST = 1'b1, Dat_Rdy_Sig = 1'b0, flush = 1'b0;
  logic [2:0] sta_in = 3'd0;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  logic [7:0] mem_a [256];
  logic [7:0] wr_a = 8'd0, rd_a = 8'd0, used_a, stage_a = 8'd0;
  logic [3:0] cnt_a;
  logic full_a, rd_req_a, pv_a, mv_a, fe_a, busy_a;
  logic [15:0] c1_a, c2_a, c3_a, c4_a, c5_a, c6_a;
  logic [23:0] d1_a, d2_a;
  logic [95:0] coefs_a;

  logic [7:0] mem_b [256];
  logic [7:0] wr_b = 8'd0, rd_b = 8'd0, used_b, stage1_b = 8'd0, stage2_b = 8'd0;
  logic [3:0] cnt_b;
  logic full_b, rd_req_b, pv_b, mv_b, fe_b, busy_b;
  logic [15:0] c1_b, c2_b, c3_b, c4_b, c5_b, c6_b;
  logic [23:0] d1_b, d2_b;
  logic [95:0] coefs_b;

  assign used_a  = wr_a - rd_a;
  assign cnt_a   = used_a[3:0];
  assign full_a  = (used_a >= 8'd16);
  assign used_b  = wr_b - rd_b;
  assign cnt_b   = used_b[3:0];
  assign full_b  = (used_b >= 8'd16);
  assign coefs_a = {c1_a, c2_a, c3_a, c4_a, c5_a, c6_a};
  assign coefs_b = {c1_b, c2_b, c3_b, c4_b, c5_b, c6_b};

  ms5611_frame_unpack #(.FIFO_RD_LAT(1)) dut_a (
    .CLK(CLK), .RST(RST), .Dat_Rdy_Sig(Dat_Rdy_Sig), .sta_in(sta_in),
    .Rx_Dat_Cnt(cnt_a), .Rx_FIFO_Full(full_a), .Rx_FIFO_dat(stage_a), .Rx_FIFO_RD_Req(rd_req_a),
    .prom_c1(c1_a), .prom_c2(c2_a), .prom_c3(c3_a), .prom_c4(c4_a), .prom_c5(c5_a), .prom_c6(c6_a),
    .prom_valid(pv_a), .d1_raw(d1_a), .d2_raw(d2_a), .meas_valid(mv_a), .frame_err(fe_a), .busy(busy_a)
  );

  ms5611_frame_unpack #(.FIFO_RD_LAT(2)) dut_b (
    .CLK(CLK), .RST(RST), .Dat_Rdy_Sig(Dat_Rdy_Sig), .sta_in(sta_in),
    .Rx_Dat_Cnt(cnt_b), .Rx_FIFO_Full(full_b), .Rx_FIFO_dat(stage2_b), .Rx_FIFO_RD_Req(rd_req_b),
    .prom_c1(c1_b), .prom_c2(c2_b), .prom_c3(c3_b), .prom_c4(c4_b), .prom_c5(c5_b), .prom_c6(c6_b),
    .prom_valid(pv_b), .d1_raw(d1_b), .d2_raw(d2_b), .meas_valid(mv_b), .frame_err(fe_b), .busy(busy_b)
  );

  // FIFO models: latency 1 returns data the cycle after the strobe, latency 2 one cycle later.
  always @(posedge CLK) begin
    if (flush) rd_a <= wr_a;
    else if (rd_req_a) begin
      stage_a <= mem_a[rd_a];
      rd_a    <= rd_a + 8'd1;
    end
    if (flush) rd_b <= wr_b;
    else if (rd_req_b) begin
      stage1_b <= mem_b[rd_b];
      rd_b     <= rd_b + 8'd1;
    end
    stage2_b <= stage1_b;
  end

  logic prev_a = 1'b0, prev_b = 1'b0;
  int b2b_a = 0, b2b_b = 0;
  always @(posedge CLK) begin
    prev_a <= rd_req_a;
    prev_b <= rd_req_b;
    if (rd_req_a && prev_a) b2b_a <= b2b_a + 1;
    if (rd_req_b && prev_b) b2b_b <= b2b_b + 1;
  end

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic load_fifo(input logic [127:0] data, input int n, input bit also_b);
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    for (int i = 0; i < n; i++) begin
      mem_a[wr_a] = data[8*(n-1-i) +: 8];
      wr_a = wr_a + 8'd1;
      if (also_b) begin
        mem_b[wr_b] = data[8*(n-1-i) +: 8];
        wr_b = wr_b + 8'd1;
      end
    end
  endtask

  task automatic start_frame(input logic [2:0] s);
    @(negedge CLK);
    Dat_Rdy_Sig = 1'b1;
    sta_in = s;
  endtask

  task automatic run_prom();
    load_fifo(PROM_BYTES, 16, 1'b0);
    start_frame(3'd1);
    @(negedge CLK);
    Dat_Rdy_Sig = 1'b0;
    repeat (36) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    total++; if (coefs_a !== 96'h0) begin bad++; $display("[TB] FAIL reset_coefs: got %h want 0", coefs_a); end
    total++; if ({pv_a, mv_a, fe_a, busy_a, rd_req_a} !== 5'b0) begin bad++; $display("[TB] FAIL reset_flags: got %b want 00000", {pv_a, mv_a, fe_a, busy_a, rd_req_a}); end
    total++; if ({d1_a, d2_a} !== 48'h0) begin bad++; $display("[TB] FAIL reset_raw: got %h want 0", {d1_a, d2_a}); end
  endtask

  task automatic test_meas_before_prom();
    int reqs = 0;
    logic mv_seen = 1'b0;
    load_fifo(48'h82C13E8AA21A, 6, 1'b0);
    start_frame(3'd4);
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      if (rd_req_a) reqs++;
      if (mv_a) mv_seen = 1'b1;
    end
    total++; if (reqs != 6) begin bad++; $display("[TB] FAIL early_meas_reads: got %0d want 6", reqs); end
    total++; if (mv_seen !== 1'b0) begin bad++; $display("[TB] FAIL early_meas_valid: got %b want 0", mv_seen); end
    total++; if (fe_a !== 1'b1) begin bad++; $display("[TB] FAIL early_meas_err: got %b want 1", fe_a); end
    total++; if ({d1_a, d2_a} !== 48'h0) begin bad++; $display("[TB] FAIL early_meas_raw: got %h want 0", {d1_a, d2_a}); end
  endtask

  task automatic test_prom();
    int reqs = 0, perr = 0;
    logic exp_req, pv32 = 1'bx, pv33 = 1'bx, busy1 = 1'bx, busy34 = 1'bx;
    do_reset();
    load_fifo(PROM_BYTES, 16, 1'b0);
    start_frame(3'd1);
    for (int n = 1; n <= 36; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      exp_req = (n <= 31) && (n % 2 == 1);
      if (rd_req_a) reqs++;
      if (rd_req_a !== exp_req) perr++;
      if (n == 1)  busy1  = busy_a;
      if (n == 32) pv32   = pv_a;
      if (n == 33) pv33   = pv_a;
      if (n == 34) busy34 = busy_a;
    end
    total++; if (reqs != 16) begin bad++; $display("[TB] FAIL prom_reads: got %0d want 16", reqs); end
    total++; if (perr != 0) begin bad++; $display("[TB] FAIL prom_read_timing: got %0d misplaced want 0", perr); end
    total++; if (pv32 !== 1'b0) begin bad++; $display("[TB] FAIL prom_valid_c32: got %b want 0", pv32); end
    total++; if (pv33 !== 1'b1) begin bad++; $display("[TB] FAIL prom_valid_c33: got %b want 1", pv33); end
    total++; if (busy1 !== 1'b1 || busy34 !== 1'b0) begin bad++; $display("[TB] FAIL prom_busy: got %b%b want 10", busy1, busy34); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (coefs_a[95-16*i -: 16] !== EXP_COEFS[95-16*i -: 16]) begin
        bad++; $display("[TB] FAIL prom_c%0d: got %h want %h", i + 1, coefs_a[95-16*i -: 16], EXP_COEFS[95-16*i -: 16]);
      end
    end
    total++; if (fe_a !== 1'b0) begin bad++; $display("[TB] FAIL prom_err: got %b want 0", fe_a); end
  endtask

  task automatic test_meas();
    int perr = 0, mverr = 0;
    logic exp_req;
    load_fifo(48'h82C13E8AA21A, 6, 1'b0);
    start_frame(3'd4);
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      exp_req = (n <= 11) && (n % 2 == 1);
      if (rd_req_a !== exp_req) perr++;
      if (mv_a !== (n == 13)) mverr++;
    end
    total++; if (perr != 0) begin bad++; $display("[TB] FAIL meas_read_timing: got %0d misplaced want 0", perr); end
    total++; if (mverr != 0) begin bad++; $display("[TB] FAIL meas_valid_pulse: got %0d bad cycles want 0", mverr); end
    total++; if (d2_a !== 24'h82C13E) begin bad++; $display("[TB] FAIL meas_d2: got %h want 82c13e", d2_a); end
    total++; if (d1_a !== 24'h8AA21A) begin bad++; $display("[TB] FAIL meas_d1: got %h want 8aa21a", d1_a); end
    total++; if (fe_a !== 1'b0 || pv_a !== 1'b1) begin bad++; $display("[TB] FAIL meas_flags: got err=%b pv=%b want err=0 pv=1", fe_a, pv_a); end
  endtask

  task automatic test_short_frame();
    int reqs = 0;
    logic mv_seen = 1'b0, fe9 = 1'bx, fe10 = 1'bx, busy10 = 1'bx;
    load_fifo(32'h11223344, 4, 1'b0);
    start_frame(3'd4);
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      if (rd_req_a) reqs++;
      if (mv_a) mv_seen = 1'b1;
      if (n == 9)  fe9 = fe_a;
      if (n == 10) begin fe10 = fe_a; busy10 = busy_a; end
    end
    total++; if (reqs != 4) begin bad++; $display("[TB] FAIL short_reads: got %0d want 4", reqs); end
    total++; if (fe9 !== 1'b0 || fe10 !== 1'b1) begin bad++; $display("[TB] FAIL short_err_timing: got %b%b want 01", fe9, fe10); end
    total++; if (mv_seen !== 1'b0 || busy10 !== 1'b0) begin bad++; $display("[TB] FAIL short_valid_busy: got %b%b want 00", mv_seen, busy10); end
    total++; if ({d2_a, d1_a} !== 48'h82C13E8AA21A) begin bad++; $display("[TB] FAIL short_raw_hold: got %h want 82c13e8aa21a", {d2_a, d1_a}); end
  endtask

  task automatic test_overlap();
    int reqs = 0, mvcnt = 0;
    logic fe4 = 1'bx, fe5 = 1'bx;
    do_reset();
    run_prom();
    load_fifo(48'h123456ABCDEF, 6, 1'b0);
    start_frame(3'd4);
    for (int n = 1; n <= 16; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      if (n == 4) begin fe4 = fe_a; Dat_Rdy_Sig = 1'b1; end
      if (n == 5) begin fe5 = fe_a; Dat_Rdy_Sig = 1'b0; end
      if (rd_req_a) reqs++;
      if (mv_a) mvcnt++;
    end
    total++; if (fe4 !== 1'b0 || fe5 !== 1'b1) begin bad++; $display("[TB] FAIL overlap_err: got %b%b want 01", fe4, fe5); end
    total++; if (reqs != 6 || mvcnt != 1) begin bad++; $display("[TB] FAIL overlap_frame: got reads=%0d pulses=%0d want 6 1", reqs, mvcnt); end
    total++; if ({d2_a, d1_a} !== 48'h123456ABCDEF) begin bad++; $display("[TB] FAIL overlap_raw: got %h want 123456abcdef", {d2_a, d1_a}); end
  endtask

  task automatic test_bad_state();
    int reqs = 0;
    logic busy_seen = 1'b0;
    do_reset();
    load_fifo(48'h010203040506, 6, 1'b0);
    start_frame(3'd2);
    for (int n = 1; n <= 6; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      if (rd_req_a) reqs++;
      if (busy_a) busy_seen = 1'b1;
    end
    total++; if (reqs != 0 || busy_seen !== 1'b0) begin bad++; $display("[TB] FAIL bad_state_idle: got reads=%0d busy=%b want 0 0", reqs, busy_seen); end
    total++; if (fe_a !== 1'b1) begin bad++; $display("[TB] FAIL bad_state_err: got %b want 1", fe_a); end
  endtask

  task automatic test_reset_mid_prom();
    int reqs_after = 0;
    logic [95:0] coefs11 = 'x;
    logic [2:0] flags11 = 'x;
    do_reset();
    run_prom();
    load_fifo(PROM_BYTES, 16, 1'b0);
    start_frame(3'd1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      if (n == 10) RST = 1'b1;
      if (n == 11) begin RST = 1'b0; coefs11 = coefs_a; flags11 = {pv_a, fe_a, busy_a}; end
      if (n >= 11 && rd_req_a) reqs_after++;
    end
    total++; if (coefs11 !== 96'h0) begin bad++; $display("[TB] FAIL midreset_coefs: got %h want 0", coefs11); end
    total++; if (flags11 !== 3'b000 || reqs_after != 0) begin bad++; $display("[TB] FAIL midreset_state: got flags=%b reads=%0d want 000 0", flags11, reqs_after); end
    run_prom();
    total++; if (coefs_a !== EXP_COEFS || pv_a !== 1'b1 || fe_a !== 1'b0) begin bad++; $display("[TB] FAIL midreset_recover: got %h pv=%b err=%b want %h 1 0", coefs_a, pv_a, fe_a, EXP_COEFS); end
  endtask

  task automatic test_lat2();
    int reqs = 0, perr = 0;
    logic exp_req, pv48 = 1'bx, pv49 = 1'bx;
    do_reset();
    load_fifo(PROM_BYTES, 16, 1'b1);
    start_frame(3'd1);
    for (int n = 1; n <= 52; n++) begin
      @(negedge CLK);
      if (n == 1) Dat_Rdy_Sig = 1'b0;
      exp_req = (n <= 46) && ((n - 1) % 3 == 0);
      if (rd_req_b) reqs++;
      if (rd_req_b !== exp_req) perr++;
      if (n == 48) pv48 = pv_b;
      if (n == 49) pv49 = pv_b;
    end
    total++; if (reqs != 16 || perr != 0) begin bad++; $display("[TB] FAIL lat2_reads: got %0d reads %0d misplaced want 16 0", reqs, perr); end
    total++; if (pv48 !== 1'b0 || pv49 !== 1'b1) begin bad++; $display("[TB] FAIL lat2_valid_timing: got %b%b want 01", pv48, pv49); end
    total++; if (coefs_b !== EXP_COEFS || fe_b !== 1'b0) begin bad++; $display("[TB] FAIL lat2_coefs: got %h err=%b want %h 0", coefs_b, fe_b, EXP_COEFS); end
    total++; if (b2b_a != 0 || b2b_b != 0) begin bad++; $display("[TB] FAIL back_to_back_reads: got %0d %0d want 0 0", b2b_a, b2b_b); end
  endtask

  initial begin
    test_reset();
    test_meas_before_prom();
    test_prom();
    test_meas();
    test_short_frame();
    test_overlap();
    test_bad_state();
    test_reset_mid_prom();
    test_lat2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ms5611_frame_unpack.md
Name: ms5611_frame_unpack

Overview:
- Sits directly downstream of the MS5611 SPI driver and drains its 16-byte receive FIFO whenever the driver pulses its data-ready strobe.
- Reassembles the bytes into typed words: PROM coefficients C1..C6 after the PROM read, and raw 24-bit D2 (temperature) and D1 (pressure) after each measurement cycle.
- Presents the words on registered outputs with single-cycle valid strobes for the compensation/arithmetic stage.

Parameters:
- FIFO_RD_LAT, 1, cycles from Rx_FIFO_RD_Req to valid Rx_FIFO_dat (1 or 2).
- STA_INIT, 3'd1, driver state code for a PROM frame.
- STA_SEND, 3'd4, driver state code for a measurement frame.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- Dat_Rdy_Sig  in  1  driver frame-complete pulse.
- sta_in  in  3  driver state, sampled with Dat_Rdy_Sig.
- Rx_Dat_Cnt  in  4  FIFO usedw.
- Rx_FIFO_Full  in  1  FIFO full.
- Rx_FIFO_dat  in  8  FIFO read data.
- Rx_FIFO_RD_Req  out  1  FIFO read strobe.
- prom_c1..prom_c6  out  16 each  calibration coefficients C1..C6.
- prom_valid  out  1  level; high once a complete PROM frame has been unpacked.
- d1_raw  out  24  raw pressure.
- d2_raw  out  24  raw temperature.
- meas_valid  out  1  one-cycle pulse; d1_raw/d2_raw updated.
- frame_err  out  1  sticky error flag.
- busy  out  1  unpacking in progress.

Behaviour:
- Reset (RST high at a CLK edge):
  - All outputs go to 0; FSM goes to IDLE; byte counter and shift registers are cleared.
  - Reset mid-frame abandons the frame; the FIFO is not drained.
- FIFO empty is defined as Rx_Dat_Cnt==0 && !Rx_FIFO_Full.
- FSM states: IDLE, RD, WAIT, CAP, DONE.
- IDLE:
  - On Dat_Rdy_Sig with sta_in==STA_INIT: frame type PROM, length 16. Go to RD.
  - On Dat_Rdy_Sig with sta_in==STA_SEND: frame type MEAS, length 6. Go to RD.
  - On Dat_Rdy_Sig with any other sta_in: set frame_err, stay in IDLE.
- RD:
  - If the FIFO is empty, set frame_err and return to IDLE. Outputs and valid flags are not updated.
  - Otherwise assert Rx_Fifo_RD_Req for exactly one cycle, then go to WAIT.
- WAIT: hold for FIFO_RD_LAT-1 cycles (0 cycles when FIFO_RD_LAT=1), then go to CAP.
- CAP:
  - Shift Rx_FIFO_dat into the frame shift register and increment the byte index k.
  - If k reaches the frame length, go to DONE; otherwise go to RD.
  - Timing: byte k is read at cycle 1+k*(FIFO_RD_LAT+1) after the Dat_Rdy_Sig cycle (cycle 0). Never two read strobes back-to-back.
- DONE, PROM frame:
  - Bytes are MSB-first; word n = {byte 2n, byte 2n+1}, n = 0..7.
  - prom_c1..c6 take words 1..6; words 0 and 7 are discarded.
  - prom_valid is set.
  - frame_err is set if any of words 1..6 is 16'h0000 or 16'hFFFF. prom_valid is still set in this case.
- DONE, MEAS frame:
  - d2_raw = {byte0,byte1,byte2}; d1_raw = {byte3,byte4,byte5}.
  - meas_valid is pulsed for 1 cycle.
  - Ignored (never pulses meas_valid) while prom_valid==0; frame_err is set instead. The FIFO is still drained.
- Latency with FIFO_RD_LAT=1:
  - MEAS: reads at cycles 1,3,5,7,9,11; meas_valid at cycle 13.
  - PROM: outputs and prom_valid update at cycle 33.
- busy is high in every state except IDLE.
- Dat_Rdy_Sig arriving while busy: ignored, frame_err set, current frame continues.
- A new PROM frame (driver re-reset) clears prom_valid at its first CAP and sets it again at DONE.
- frame_err clears only on RST.
- Outputs hold their last values between frames.

Test Plan:
- PROM frame: preload the FIFO with 16 bytes 00 00, 9C BF, 90 3C, 5B 15, 5A F2, 82 B8, 6E 98, 00 0B; pulse Dat_Rdy_Sig with sta_in=1 -> prom_c1=9CBF, c2=903C, c3=5B15, c4=5AF2, c5=82B8, c6=6E98; prom_valid=1 at cycle 33; exactly 16 read strobes; frame_err=0.
- Measurement frame after PROM: bytes 82 C1 3E, 8A A2 1A with sta_in=4 -> d2_raw=82C13E, d1_raw=8AA21A; meas_valid high for one cycle at cycle 13.
- Short frame: only 4 bytes present at a MEAS strobe -> 4 read strobes; frame_err=1 at the 5th RD; meas_valid never pulses; d1_raw/d2_raw unchanged.
- Measurement before PROM: MEAS frame with prom_valid=0 -> 6 bytes drained; meas_valid=0; frame_err=1.
- Overlap and bad state: Dat_Rdy_Sig at cycle 4 of a MEAS frame -> frame completes normally; frame_err=1. Dat_Rdy_Sig with sta_in=2 -> no reads; frame_err=1.
- Reset mid-PROM frame at cycle 10 -> all outputs 0; no further read strobes; a subsequent full PROM frame succeeds. Repeat the PROM case with FIFO_RD_LAT=2 -> reads every 3 cycles; identical words.
